// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Serial-to-parallel UART receiver. The frame format is 8 data bits, no parity
// and 1 stop bit, sent LSB first on an idle-high line. The line is brought into
// the i_clk domain through a two-flop synchroniser. A start bit is confirmed at
// its centre, and every later bit is sampled one full bit period after the
// previous sample, so each sample lands at a nominal bit centre.
//
// Parameters
//   CLKS_PER_BIT : i_clk cycles per serial bit (>= 4). The default of 838
//                  corresponds to 50 MHz / ~59.67 kbaud.
//
// Ports
//   i_clk       in   system clock; all state changes on the rising edge
//   i_rst       in   synchronous, active-high reset
//   i_rx_serial in   asynchronous serial line, idle = 1
//   o_done      out  one-cycle pulse; a valid frame was received and
//                    o_rx_byte was updated on the same edge
//   err         out  one-cycle pulse; framing error (stop bit sampled as 0)
//   o_rx_byte   out  last correctly received byte, held until the next
//                    valid frame
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 838
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial,
    output logic       o_done,
    output logic       err,
    output logic [7:0] o_rx_byte
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    // Terminal counts for the half-bit start check and for full-bit periods.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    // Both stages reset to the idle level. A low line coming out of reset
    // therefore produces a clean high-to-low transition on rx_s two clocks
    // later. IDLE triggers on the level, not on an edge, so that low line is
    // still taken as a start bit.
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], i_rx_serial};
        end
    end

    assign rx_s = sync_reg[1];

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       data_sr_reg, data_sr_next;
    logic [7:0]       rx_byte_reg, rx_byte_next;
    logic             done_reg,    done_next;
    logic             err_reg,     err_next;

    // Strobes from the FSM to the datapath.
    logic             sample_bit;   // capture rx_s into data_sr[bit_idx]
    logic             load_byte;    // publish data_sr on o_rx_byte

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        sample_bit   = 1'b0;
        load_byte    = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next     = '0;
                bit_idx_next = 3'd0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                // Look again half a bit later. A line that has returned high
                // by then was a glitch, not a start bit.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = S_DATA;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next   = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    sample_bit   = 1'b1;
                    // This wraps from 7 back to 0, which is the value the next
                    // frame needs anyway.
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_STOP: begin
                // The decision is taken at mid stop bit. The receiver is back
                // in IDLE about half a bit before the next start edge can
                // arrive, so frames with no idle gap are still accepted.
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        done_next  = 1'b1;
                        load_byte  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_BREAK: begin
                // Stay here while the line is held low (a break or a broken
                // link), so that a stuck-low line cannot produce a stream of
                // bogus frames.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next   = S_IDLE;
                cnt_next     = '0;
                bit_idx_next = 3'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Shift register: one bit lane per data bit
    // -------------------------------------------------------------------------
    // Each lane updates only on the sample strobe for its own bit index.
    // Frames arrive LSB first, so bit k of the frame lands directly in lane k.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sr_lane
            assign data_sr_next[gi] =
                (sample_bit && (bit_idx_reg == 3'(gi))) ? rx_s : data_sr_reg[gi];
        end
    endgenerate

    // The byte register changes only when a frame ends with a good stop bit.
    // A framing error leaves the previously received value in place.
    assign rx_byte_next = load_byte ? data_sr_reg : rx_byte_reg;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // A reset during a frame abandons it at once. No pulse is produced, and
    // because the synchroniser also reloads the idle level, a fresh start bit
    // is needed before another frame is received.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= 3'd0;
            data_sr_reg <= 8'h00;
            rx_byte_reg <= 8'h00;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            data_sr_reg <= data_sr_next;
            rx_byte_reg <= rx_byte_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // done_next and err_next come from opposite branches of the STOP
    // decision, so the two pulses can never be high together.
    assign o_done    = done_reg;
    assign err       = err_reg;
    assign o_rx_byte = rx_byte_reg;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Testbench for uart_rx. It instantiates two receivers:
//   dut_a : CLKS_PER_BIT = 838, used for the nominal-rate frames
//   dut_b : CLKS_PER_BIT = 16,  used for the glitch, framing-error,
//           back-to-back, random and reset tests
//
// Each frame the bench sends produces an expected event, computed from the
// frame contents and the send cycle:
//   good stop bit : o_done pulse carrying the byte, seen at
//                   send_cycle + 3 + CPB/2 + 9*CPB
//   bad stop bit  : err pulse at that same cycle
// A monitor records the observed pulses, and the directed steps compare the
// two lists after each scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB_A = 838;
    localparam int CPB_B = 16;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b;
    logic       done_a, done_b;
    logic       err_a, err_b;
    logic [7:0] byte_a, byte_b;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_serial (rx_a),
        .o_done      (done_a),
        .err         (err_a),
        .o_rx_byte   (byte_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_serial (rx_b),
        .o_done      (done_b),
        .err         (err_b),
        .o_rx_byte   (byte_b)
    );

    // Count of rising edges seen so far.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed and expected event lists.
    ev_t         obs_done_a[$], obs_done_b[$], exp_done_a[$], exp_done_b[$];
    logic [31:0] obs_err_a[$],  obs_err_b[$],  exp_err_a[$],  exp_err_b[$];
    logic [7:0]  last_good[2];
    int          both_high = 0;

    int vectors    = 0;
    int miscompares = 0;

    // Monitor: sample the outputs on the falling edge, away from the
    // rising edge where they change.
    always @(negedge clk) begin
        if (done_a === 1'b1) obs_done_a.push_back({byte_a, cyc});
        if (err_a  === 1'b1) obs_err_a.push_back(cyc);
        if (done_b === 1'b1) obs_done_b.push_back({byte_b, cyc});
        if (err_b  === 1'b1) obs_err_b.push_back(cyc);
        if (done_a === 1'b1 && err_a === 1'b1) both_high++;
        if (done_b === 1'b1 && err_b === 1'b1) both_high++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // Send one frame starting now (1 time unit after a rising edge). The stop
    // bit is driven as stop_v and held for stop_len clocks.
    task automatic send_frame(input bit sel, input logic [7:0] data,
                              input logic stop_v, input int stop_len);
        int          cpb;
        logic [31:0] due;
        logic [8:0]  bits;
        cpb  = sel ? CPB_B : CPB_A;
        due  = cyc + 3 + cpb / 2 + 9 * cpb;
        bits = {data, 1'b0};
        if (stop_v) begin
            if (sel) exp_done_b.push_back({data, due});
            else     exp_done_a.push_back({data, due});
            last_good[sel] = data;
        end else begin
            if (sel) exp_err_b.push_back(due);
            else     exp_err_a.push_back(due);
        end
        for (int i = 0; i < 9; i++) begin
            set_line(sel, bits[i]);
            tick(cpb);
        end
        set_line(sel, stop_v);
        tick(stop_len);
    endtask

    // Compare the observed pulses with the expected ones, check that the held
    // byte is unchanged, then clear both lists.
    task automatic compare_events(input bit sel, input string tag);
        ev_t         od[$], ed[$];
        logic [31:0] oe[$], ee[$];
        logic [7:0]  cur;
        if (sel) begin
            od = obs_done_b; ed = exp_done_b; oe = obs_err_b; ee = exp_err_b; cur = byte_b;
        end else begin
            od = obs_done_a; ed = exp_done_a; oe = obs_err_a; ee = exp_err_a; cur = byte_a;
        end
        check({tag, "_ndone"}, 32'(od.size()), 32'(ed.size()));
        for (int i = 0; i < ed.size(); i++) begin
            if (i < od.size()) begin
                check({tag, "_byte"}, 32'(od[i].data), 32'(ed[i].data));
                check({tag, "_donecyc"}, od[i].at, ed[i].at);
            end
        end
        check({tag, "_nerr"}, 32'(oe.size()), 32'(ee.size()));
        for (int i = 0; i < ee.size(); i++) begin
            if (i < oe.size()) check({tag, "_errcyc"}, oe[i], ee[i]);
        end
        check({tag, "_held"}, 32'(cur), 32'(last_good[sel]));
        if (sel) begin
            obs_done_b.delete(); exp_done_b.delete(); obs_err_b.delete(); exp_err_b.delete();
        end else begin
            obs_done_a.delete(); exp_done_a.delete(); obs_err_a.delete(); exp_err_a.delete();
        end
    endtask

    initial begin
        logic [8:0] c3_bits;
        rst  = 1'b1;
        rx_a = 1'b0;
        rx_b = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        tick(1);

        // Reset held with both lines low: every output must stay at 0.
        for (int i = 0; i < 4; i++) begin
            check("rst_done_a", 32'(done_a), 32'd0);
            check("rst_err_a",  32'(err_a),  32'd0);
            check("rst_byte_a", 32'(byte_a), 32'd0);
            check("rst_done_b", 32'(done_b), 32'd0);
            check("rst_err_b",  32'(err_b),  32'd0);
            check("rst_byte_b", 32'(byte_b), 32'd0);
            tick(1);
        end
        rx_a = 1'b1;
        rx_b = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(4);
        compare_events(1'b0, "post_rst_a");
        compare_events(1'b1, "post_rst_b");

        // Nominal-rate frame 0xA5, then a random byte, on dut_a.
        send_frame(1'b0, 8'hA5, 1'b1, CPB_A);
        tick(10);
        compare_events(1'b0, "nominal_a5");
        tick(2 * CPB_A);
        check("nominal_hold", 32'(byte_a), 32'h0A5);
        send_frame(1'b0, 8'($urandom), 1'b1, CPB_A);
        tick(10);
        compare_events(1'b0, "nominal_rand");

        // Glitch: the line is low for only 3 clocks.
        set_line(1'b1, 1'b0);
        tick(3);
        set_line(1'b1, 1'b1);
        tick(40);
        compare_events(1'b1, "glitch");
        send_frame(1'b1, 8'h3C, 1'b1, CPB_B);
        tick(5);
        compare_events(1'b1, "glitch_3c");

        // Framing error: 0x81 with its stop bit held low for 40 clocks.
        send_frame(1'b1, 8'h5A, 1'b1, CPB_B);
        tick(5);
        compare_events(1'b1, "ferr_5a");
        send_frame(1'b1, 8'h81, 1'b0, 40);
        compare_events(1'b1, "ferr_81");
        set_line(1'b1, 1'b1);
        tick(30);
        compare_events(1'b1, "ferr_quiet");
        send_frame(1'b1, 8'h7E, 1'b1, CPB_B);
        tick(5);
        compare_events(1'b1, "ferr_7e");

        // Back-to-back frames with no idle gap; pulses fall 160 clocks apart.
        send_frame(1'b1, 8'h00, 1'b1, CPB_B);
        send_frame(1'b1, 8'hFF, 1'b1, CPB_B);
        send_frame(1'b1, 8'h55, 1'b1, CPB_B);
        tick(5);
        compare_events(1'b1, "b2b");

        // Random bytes with random idle gaps between frames.
        for (int i = 0; i < 24; i++) begin
            send_frame(1'b1, 8'($urandom), 1'b1, CPB_B);
            tick($urandom_range(0, 20));
        end
        tick(5);
        compare_events(1'b1, "random");

        // Reset during bit 4 of 0xC3. The transmitter is abandoned too, so
        // the line goes back to idle.
        c3_bits = {8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            set_line(1'b1, c3_bits[i]);
            tick(CPB_B);
        end
        set_line(1'b1, c3_bits[5]);
        tick(5);
        rst = 1'b1;
        set_line(1'b1, 1'b1);
        tick(1);
        rst = 1'b0;
        check("rstmid_done", 32'(done_b), 32'd0);
        check("rstmid_err",  32'(err_b),  32'd0);
        check("rstmid_byte", 32'(byte_b), 32'd0);
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        tick(3 * CPB_B * 10);
        compare_events(1'b1, "rstmid_b");
        compare_events(1'b0, "rstmid_a");
        send_frame(1'b1, 8'h99, 1'b1, CPB_B);
        tick(5);
        compare_events(1'b1, "rstmid_99");

        check("done_err_exclusive", 32'(both_high), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
